receptor_nota_buzzer: RTL

//  Receive end of the 3-bit note link driven by the game datapath's Arduino output (arduino_out).

---
 rtl/receptor_nota_buzzer_pkg.sv | 31 +++
 rtl/receptor_nota_buzzer_if.sv | 34 +++
 rtl/receptor_nota_buzzer_sincronizador_filtro.sv | 57 +++++
 rtl/receptor_nota_buzzer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/receptor_nota_buzzer_pkg.sv
// Shared definitions for the note link receiver: note codes, pitch table and FSM encoding.
// The tone table is derived from the local clock frequency at elaboration time.
package notas_pkg;

    localparam logic [2:0] NOTA_SILENCIO = 3'd0;
    localparam logic [2:0] NOTA_C4       = 3'd1;
    localparam logic [2:0] NOTA_D4       = 3'd2;
    localparam logic [2:0] NOTA_E4       = 3'd3;
    localparam logic [2:0] NOTA_F4       = 3'd4;
    localparam logic [2:0] NOTA_G4       = 3'd5;
    localparam logic [2:0] NOTA_A4       = 3'd6;
    localparam logic [2:0] NOTA_B4       = 3'd7;

    // Index 0 is silence and has no pitch.
    localparam int unsigned NOTA_FREQ_HZ [8] = '{0, 262, 294, 330, 349, 392, 440, 494};

    typedef enum logic [1:0] {
        SILENCIO = 2'd0,
        TOCANDO  = 2'd1,
        SUSTENTA = 2'd2
    } estado_t;

    // Clock cycles per half period of note k, floored; 0 for silence.
    function automatic int unsigned meio_periodo(input int unsigned clk_hz, input logic [2:0] k);
        if (k == NOTA_SILENCIO) begin
            return 0;
        end
        return clk_hz / (2 * NOTA_FREQ_HZ[k]);
    endfunction

endpackage

// File: rtl/receptor_nota_buzzer_if.sv
// Signal bundle between the note link / control side and the buzzer receiver.
// The link is level-coded with no handshake: codigo_nota is sampled asynchronously, habilita is synchronous.
interface receptor_nota_buzzer_if;
    import notas_pkg::*;

    logic [2:0] codigo_nota;
    logic       habilita;
    logic       buzzer;
    logic [2:0] nota_atual;
    logic       tocando;
    logic       nova_nota;
    estado_t    estado_dbg;

    modport master (
        output codigo_nota,
        output habilita,
        input  buzzer,
        input  nota_atual,
        input  tocando,
        input  nova_nota,
        input  estado_dbg
    );

    modport slave (
        input  codigo_nota,
        input  habilita,
        output buzzer,
        output nota_atual,
        output tocando,
        output nova_nota,
        output estado_dbg
    );

endinterface

// File: rtl/receptor_nota_buzzer_sincronizador_filtro.sv
// Two-flop synchroniser followed by a stability filter: a code is accepted only after
// STABLE_CYCLES consecutive identical synced samples.
module sincronizador_filtro #(
    parameter int unsigned W             = 3,
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] dado_i,
    output logic [W-1:0] codigo_aceito_o
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ALVO = CNT_W'(STABLE_CYCLES);

    logic [W-1:0]     sync1_q;
    logic [W-1:0]     sync2_q;
    logic [W-1:0]     ultimo_q;
    logic [W-1:0]     aceito_q;
    logic [W-1:0]     aceito_d;
    logic [CNT_W-1:0] cont_q;
    logic [CNT_W-1:0] cont_d;

    // cont counts how many consecutive samples (including this one) equal sync2_q.
    // Intermediate codes of a multi-bit transition last a single sample and never reach the target.
    always_comb begin
        cont_d   = cont_q;
        aceito_d = aceito_q;
        if (sync2_q != ultimo_q) begin
            cont_d = CNT_W'(1);
        end else if (cont_q < CNT_ALVO) begin
            cont_d = cont_q + CNT_W'(1);
        end
        if (cont_d >= CNT_ALVO) begin
            aceito_d = sync2_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            ultimo_q <= '0;
            cont_q   <= '0;
            aceito_q <= '0;
        end else begin
            sync1_q  <= dado_i;
            sync2_q  <= sync1_q;
            ultimo_q <= sync2_q;
            cont_q   <= cont_d;
            aceito_q <= aceito_d;
        end
    end

    assign codigo_aceito_o = aceito_q;

endmodule

// File: rtl/receptor_nota_buzzer.sv
// Buzzer receiver: filters the 3-bit note code and drives a square wave at the note's pitch,
// holding each started note for at least MIN_NOTE_CYCLES.
module receptor_nota_buzzer
    import notas_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned STABLE_CYCLES   = 16,
    parameter int unsigned MIN_NOTE_CYCLES = 2_500_000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    receptor_nota_buzzer_if.slave bus
);

    localparam int unsigned HALF_TAB [8] = '{
        0,
        meio_periodo(CLK_HZ, NOTA_C4),
        meio_periodo(CLK_HZ, NOTA_D4),
        meio_periodo(CLK_HZ, NOTA_E4),
        meio_periodo(CLK_HZ, NOTA_F4),
        meio_periodo(CLK_HZ, NOTA_G4),
        meio_periodo(CLK_HZ, NOTA_A4),
        meio_periodo(CLK_HZ, NOTA_B4)
    };
    localparam int unsigned HALF_C4 = meio_periodo(CLK_HZ, NOTA_C4);
    localparam int HP_W  = $clog2(HALF_C4 + 1);
    localparam int DUR_W = $clog2(MIN_NOTE_CYCLES + 1);
    localparam logic [DUR_W-1:0] DUR_MAX = DUR_W'(MIN_NOTE_CYCLES);

    logic [2:0]       codigo_aceito;
    estado_t          estado_q, estado_d;
    logic [2:0]       nota_q, nota_d;
    logic             buzzer_q, buzzer_d;
    logic             tocando_q, tocando_d;
    logic             nova_q, nova_d;
    logic [HP_W-1:0]  meio_q, meio_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [HP_W-1:0]  meio_lim;
    logic             fim_meio;
    logic             dur_ok;
    logic             iniciar;
    logic             silenciar;

    sincronizador_filtro #(
        .W             (3),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filtro (
        .clock           (clock),
        .reset_n         (reset_n),
        .dado_i          (bus.codigo_nota),
        .codigo_aceito_o (codigo_aceito)
    );

    assign meio_lim = HP_W'(HALF_TAB[nota_q]);
    assign fim_meio = (meio_q == meio_lim - HP_W'(1));
    // dur_ok means this edge completes at least MIN_NOTE_CYCLES of sound since the note started.
    assign dur_ok   = (dur_q >= DUR_MAX - DUR_W'(1));

    always_comb begin
        estado_d  = estado_q;
        iniciar   = 1'b0;
        silenciar = 1'b0;
        if (!bus.habilita) begin
            silenciar = 1'b1;
        end else begin
            case (estado_q)
                SILENCIO: begin
                    if (codigo_aceito != NOTA_SILENCIO) iniciar = 1'b1;
                end
                TOCANDO: begin
                    if (codigo_aceito == NOTA_SILENCIO) begin
                        if (dur_ok) silenciar = 1'b1;
                        else        estado_d  = SUSTENTA;
                    end else if (codigo_aceito != nota_q) begin
                        iniciar = 1'b1;
                    end
                end
                SUSTENTA: begin
                    if (codigo_aceito != NOTA_SILENCIO) iniciar   = 1'b1;
                    else if (dur_ok)                    silenciar = 1'b1;
                end
                default: silenciar = 1'b1;
            endcase
        end
        if (iniciar)   estado_d = TOCANDO;
        if (silenciar) estado_d = SILENCIO;
    end

    // Datapath follows the chosen next state: clear when silent, restart low on a new note, else run.
    always_comb begin
        nota_d    = nota_q;
        buzzer_d  = buzzer_q;
        meio_d    = meio_q;
        dur_d     = dur_q;
        nova_d    = 1'b0;
        tocando_d = (estado_d != SILENCIO);
        if (estado_d == SILENCIO) begin
            nota_d   = NOTA_SILENCIO;
            buzzer_d = 1'b0;
            meio_d   = '0;
            dur_d    = '0;
        end else if (iniciar) begin
            nota_d   = codigo_aceito;
            nova_d   = 1'b1;
            buzzer_d = 1'b0;
            meio_d   = '0;
            dur_d    = '0;
        end else begin
            if (fim_meio) begin
                meio_d   = '0;
                buzzer_d = ~buzzer_q;
            end else begin
                meio_d = meio_q + HP_W'(1);
            end
            if (dur_q != DUR_MAX) dur_d = dur_q + DUR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q  <= SILENCIO;
            nota_q    <= NOTA_SILENCIO;
            buzzer_q  <= 1'b0;
            tocando_q <= 1'b0;
            nova_q    <= 1'b0;
            meio_q    <= '0;
            dur_q     <= '0;
        end else begin
            estado_q  <= estado_d;
            nota_q    <= nota_d;
            buzzer_q  <= buzzer_d;
            tocando_q <= tocando_d;
            nova_q    <= nova_d;
            meio_q    <= meio_d;
            dur_q     <= dur_d;
        end
    end

    assign bus.buzzer     = buzzer_q;
    assign bus.nota_atual = nota_q;
    assign bus.tocando    = tocando_q;
    assign bus.nova_nota  = nova_q;
    assign bus.estado_dbg = estado_q;

endmodule
